maze_mem: RTL

- Maze storage that sits directly beside the maze solver. It owns the 2^maze_width x 2^maze_width cell array.
- The array is preloaded row-major over a valid/ready stream. The block then answers the solver's synchronous read (maze_oe) and mark (maze_we) requests.
- It counts marked path cells and freezes once the solver reports done.

---
 rtl/maze_pkg.sv | 24 ++
 rtl/maze_mem_if.sv | 28 ++
 rtl/maze_cell_ram.sv | 28 ++
 rtl/maze_mem.sv | 130 +++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared definitions for the maze storage block: default size, FSM states,
// the stored cell layout and the (row, col) -> linear index helper.
package maze_pkg;

    localparam int MAZE_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SERVE  = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

    typedef struct packed {
        logic wall;
        logic visited;
    } cell_t;

    // Row-major linear index, identical to the order the loader streams cells.
    function automatic logic [2*MAZE_WIDTH-1:0] cell_idx(input logic [MAZE_WIDTH-1:0] row,
                                                         input logic [MAZE_WIDTH-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/maze_mem_if.sv
// Loader and solver signals of the maze storage block; the block uses the
// slave view, whoever drives the loader/solver side uses the master view.
interface maze_mem_if #(
    parameter int maze_width = maze_pkg::MAZE_WIDTH
);
    logic                  load_valid;
    logic                  load_data;
    logic                  load_ready;
    logic                  maze_ready;
    logic [maze_width-1:0] row;
    logic [maze_width-1:0] col;
    logic                  maze_oe;
    logic                  maze_we;
    logic                  maze_in;
    logic                  done;
    logic [2*maze_width:0] path_len;
    logic                  wall_write_err;

    modport master (
        output load_valid, load_data, row, col, maze_oe, maze_we, done,
        input  load_ready, maze_ready, maze_in, path_len, wall_write_err
    );

    modport slave (
        input  load_valid, load_data, row, col, maze_oe, maze_we, done,
        output load_ready, maze_ready, maze_in, path_len, wall_write_err
    );
endinterface

// File: rtl/maze_cell_ram.sv
// Cell array: 2-bit words (wall, visited), one synchronous write port and
// one registered read port, so it maps onto a plain block RAM.
module maze_cell_ram
    import maze_pkg::*;
#(
    parameter int addr_w = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [addr_w-1:0] wr_addr,
    input  cell_t             wr_data,
    input  logic              rd_en,
    input  logic [addr_w-1:0] rd_addr,
    output cell_t             rd_data
);
    cell_t mem_q [2**addr_w];
    cell_t rd_data_q;

    // NOTE: neither the array nor its read register is reset; a reset would
    // stop the storage from mapping onto RAM, and the loader rewrites every cell.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/maze_mem.sv
// Maze storage beside the solver: row-major preload, registered wall reads,
// visited marking with a distinct-cell counter, frozen once the solver is done.
module maze_mem
    import maze_pkg::*;
#(
    parameter int maze_width = MAZE_WIDTH
) (
    input logic       clk,
    input logic       rst_n,
    maze_mem_if.slave bus
);
    localparam int IDX_W = 2 * maze_width;
    localparam int LEN_W = IDX_W + 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] load_idx_q, load_idx_d;
    logic             load_ready_q, load_ready_d;
    logic             maze_ready_q, maze_ready_d;
    logic             mark_pend_q, mark_pend_d;
    logic [IDX_W-1:0] mark_addr_q, mark_addr_d;
    logic             fwd_q, fwd_d;
    logic             rd_oe_q, rd_oe_d;
    logic             hold_q, hold_d;
    logic [LEN_W-1:0] path_len_q, path_len_d;
    logic             wall_err_q, wall_err_d;

    logic [IDX_W-1:0] sel_addr;
    logic [IDX_W-1:0] wr_addr;
    logic             serving, load_fire, rd_en, mark_wr, wr_en, maze_in;
    cell_t            wr_data, rd_cell;

    assign sel_addr  = {bus.row, bus.col};
    assign serving   = (state_q != ST_LOAD);
    assign load_fire = (state_q == ST_LOAD) && load_ready_q && bus.load_valid;
    assign rd_en     = (serving && bus.maze_oe) || ((state_q == ST_SERVE) && bus.maze_we);

    // A mark is read-modify-write: the cell is read at the request edge and
    // committed one cycle later, once its wall/visited bits are known.
    assign mark_wr   = mark_pend_q && !rd_cell.wall;
    assign wr_en     = load_fire || mark_wr;
    assign wr_addr   = serving ? mark_addr_q : load_idx_q;
    assign wr_data   = serving ? cell_t'{wall: 1'b0, visited: 1'b1}
                               : cell_t'{wall: bus.load_data, visited: 1'b0};

    // maze_in follows the RAM only after a solver read; mark-only reads must not disturb it.
    assign maze_in   = rd_oe_q ? rd_cell.wall : hold_q;

    maze_cell_ram #(.addr_w(IDX_W)) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_en  (rd_en),
        .rd_addr(sel_addr),
        .rd_data(rd_cell)
    );

    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        load_idx_d = load_idx_q;
        path_len_d = path_len_q;
        wall_err_d = wall_err_q;

        case (state_q)
            ST_LOAD: begin
                if (load_fire) begin
                    load_idx_d = load_idx_q + IDX_W'(1);
                    if (&load_idx_q) state_d = ST_SERVE;
                end
            end
            ST_SERVE: if (bus.done) state_d = ST_FROZEN;
            default: ;
        endcase

        // A mark issued on the done cycle is still pending here, so it completes in FROZEN.
        if (mark_pend_q) begin
            if (rd_cell.wall) begin
                wall_err_d = 1'b1;
            end else if (!(rd_cell.visited || fwd_q)) begin
                path_len_d = path_len_q + LEN_W'(1);
            end
        end

        load_ready_d = (state_d == ST_LOAD);
        maze_ready_d = (state_d != ST_LOAD);
        mark_pend_d  = (state_q == ST_SERVE) && bus.maze_we;
        mark_addr_d  = sel_addr;
        // The RAM returns pre-write data when a cell is read on the edge it is marked.
        fwd_d        = mark_wr && rd_en && (sel_addr == mark_addr_q);
        rd_oe_d      = serving && bus.maze_oe;
        hold_d       = maze_in;
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            load_idx_q   <= '0;
            load_ready_q <= 1'b0;
            maze_ready_q <= 1'b0;
            mark_pend_q  <= 1'b0;
            mark_addr_q  <= '0;
            fwd_q        <= 1'b0;
            rd_oe_q      <= 1'b0;
            hold_q       <= 1'b1;
            path_len_q   <= '0;
            wall_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_idx_q   <= load_idx_d;
            load_ready_q <= load_ready_d;
            maze_ready_q <= maze_ready_d;
            mark_pend_q  <= mark_pend_d;
            mark_addr_q  <= mark_addr_d;
            fwd_q        <= fwd_d;
            rd_oe_q      <= rd_oe_d;
            hold_q       <= hold_d;
            path_len_q   <= path_len_d;
            wall_err_q   <= wall_err_d;
        end
    end

    assign bus.load_ready     = load_ready_q;
    assign bus.maze_ready     = maze_ready_q;
    assign bus.maze_in        = maze_in;
    assign bus.path_len       = path_len_q;
    assign bus.wall_write_err = wall_err_q;

endmodule
